// File: rtl/param_data_memory_if.sv
// param_data_memory_if: MEM-stage load/store bus between pipeline (master) and data memory (slave)
//   READ/WRITE/FUNCT3/ADDRESS/WRITEDATA : request from pipeline, held until BUSYWAIT low
//   READDATA/BUSYWAIT/ERR               : load result, stall, one-cycle error pulse
interface param_data_memory_if;
  logic        READ;
  logic        WRITE;
  logic [2:0]  FUNCT3;
  logic [31:0] ADDRESS;
  logic [31:0] WRITEDATA;
  logic [31:0] READDATA;
  logic        BUSYWAIT;
  logic        ERR;
  modport master(output READ, WRITE, FUNCT3, ADDRESS, WRITEDATA, input READDATA, BUSYWAIT, ERR);
  modport slave(input READ, WRITE, FUNCT3, ADDRESS, WRITEDATA, output READDATA, BUSYWAIT, ERR);
endinterface

// File: rtl/param_data_memory.sv
// param_data_memory: byte-addressable little-endian RV32 data memory, counter-timed, BUSYWAIT stall
//   CLK, RESET (async, active-high) plain ports; bus is the slave side of param_data_memory_if
module param_data_memory #(
  parameter int ADDR_WIDTH  = 10,
  parameter int LATENCY     = 5,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input logic CLK,
  input logic RESET,
  param_data_memory_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, a1, a2, a3;
  logic [31:0]           wd_q, wd_d, rdata_q, rdata_d, ld;
  logic [7:0]            mem_q [2**ADDR_WIDTH];
  logic                  cap, fire, illegal, misaligned, bad, we, unused_addr;
  assign unused_addr = ^bus.ADDRESS[31:ADDR_WIDTH];
  assign a1 = addr_q + ADDR_WIDTH'(1);
  assign a2 = addr_q + ADDR_WIDTH'(2);
  assign a3 = addr_q + ADDR_WIDTH'(3);
  always_comb begin
    cap        = state_q == IDLE && (bus.READ || bus.WRITE);
    fire       = state_q == ACCESS && cnt_q == '0;
    illegal    = wr_q ? (f3_q[2] || f3_q[1:0] == 2'b11) : (f3_q[1:0] == 2'b11 || f3_q[2:1] == 2'b11);
    misaligned = ALIGN_CHECK && (f3_q[0] ? addr_q[0] : (f3_q[1] && addr_q[1:0] != 2'b00));
    bad        = illegal || misaligned;
    we         = fire && wr_q && !bad;
    ld         = f3_q[1] ? {mem_q[a3], mem_q[a2], mem_q[a1], mem_q[addr_q]} :
                 f3_q[0] ? {{16{!f3_q[2] && mem_q[a1][7]}}, mem_q[a1], mem_q[addr_q]} :
                           {{24{!f3_q[2] && mem_q[addr_q][7]}}, mem_q[addr_q]};
    state_d    = cap ? ACCESS : fire ? DONE : state_q == ACCESS ? ACCESS : IDLE;
    cnt_d      = cap ? CNT_INIT : (state_q == ACCESS && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    wr_d       = cap ? bus.WRITE : wr_q;
    f3_d       = cap ? bus.FUNCT3 : f3_q;
    addr_d     = cap ? bus.ADDRESS[ADDR_WIDTH-1:0] : addr_q;
    wd_d       = cap ? bus.WRITEDATA : wd_q;
    rdata_d    = (fire && !wr_q) ? (bad ? '0 : ld) : rdata_q;
  end
  assign bus.BUSYWAIT = state_q == ACCESS || (state_q == IDLE && (bus.READ || bus.WRITE));
  assign bus.ERR      = state_q == DONE && bad;
  assign bus.READDATA = rdata_q;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
    end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      mem_q <= '{default: 8'h00};
    end else if (we) begin
      mem_q[addr_q] <= wd_q[7:0];
      if (f3_q[1:0] != 2'b00) mem_q[a1] <= wd_q[15:8];
      if (f3_q[1]) begin
        mem_q[a2] <= wd_q[23:16];
        mem_q[a3] <= wd_q[31:24];
      end
    end
endmodule

// File: tb/tb_param_data_memory.sv
// tb_param_data_memory: directed self-checking bench for param_data_memory (default, unaligned-allowed, LATENCY=1)
module tb_param_data_memory;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic drd = 1'b0, dwr = 1'b0;
  logic [2:0] df3 = '0;
  logic [31:0] da = '0, dwd = '0;
  int dsel = 0;
  int errors = 0, checks = 0;
  int n;
  bit e, eb;
  logic [31:0] q;
  logic busy_m, err_m;
  logic [31:0] rd_m;
  param_data_memory_if i0 ();
  param_data_memory_if i1 ();
  param_data_memory_if i2 ();
  assign i0.READ = drd && dsel == 0;
  assign i0.WRITE = dwr && dsel == 0;
  assign i1.READ = drd && dsel == 1;
  assign i1.WRITE = dwr && dsel == 1;
  assign i2.READ = drd && dsel == 2;
  assign i2.WRITE = dwr && dsel == 2;
  assign i0.FUNCT3 = df3;
  assign i1.FUNCT3 = df3;
  assign i2.FUNCT3 = df3;
  assign i0.ADDRESS = da;
  assign i1.ADDRESS = da;
  assign i2.ADDRESS = da;
  assign i0.WRITEDATA = dwd;
  assign i1.WRITEDATA = dwd;
  assign i2.WRITEDATA = dwd;
  param_data_memory u0 (.CLK(CLK), .RESET(RESET), .bus(i0));
  param_data_memory #(.ALIGN_CHECK(1'b0)) u1 (.CLK(CLK), .RESET(RESET), .bus(i1));
  param_data_memory #(.LATENCY(1)) u2 (.CLK(CLK), .RESET(RESET), .bus(i2));
  always_comb begin
    busy_m = dsel == 0 ? i0.BUSYWAIT : dsel == 1 ? i1.BUSYWAIT : i2.BUSYWAIT;
    err_m  = dsel == 0 ? i0.ERR : dsel == 1 ? i1.ERR : i2.ERR;
    rd_m   = dsel == 0 ? i0.READDATA : dsel == 1 ? i1.READDATA : i2.READDATA;
  end
  initial forever #5 CLK = ~CLK;

  task automatic go(input int d, input bit r, input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    dsel = d; drd = r; dwr = w; df3 = f3; da = a; dwd = wd;
    #1;
    if (!busy_m) begin
      @(negedge CLK);
      #1;
    end
    n = 0;
    eb = 0;
    while (busy_m && n < 100) begin
      n++;
      eb |= err_m;
      @(negedge CLK);
      #1;
    end
    e = err_m;
    q = rd_m;
  endtask

  task automatic idle();
    drd = 0; dwr = 0;
    @(negedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #1 RESET = 1'b1;
    #1;
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_m); end
    checks++; if (rd_m !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=00000000", rd_m); end
    checks++; if (err_m !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_m); end
    @(negedge CLK);
    RESET = 1'b0;
    #1;
  endtask

  task automatic test_word();
    go(0, 0, 1, 3'b010, 32'h10, 32'h8899AABB);
    checks++; if (n !== 6) begin errors++; $display("FAIL sw_busy_cycles got=%0d exp=6", n); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL sw_err got=%b exp=0", e); end
    checks++; if (eb !== 1'b0) begin errors++; $display("FAIL sw_err_early got=%b exp=0", eb); end
    go(0, 1, 0, 3'b010, 32'h10, 32'h0);
    checks++; if (n !== 6) begin errors++; $display("FAIL lw_busy_cycles got=%0d exp=6", n); end
    checks++; if (q !== 32'h8899AABB) begin errors++; $display("FAIL lw_data got=%h exp=8899aabb", q); end
    go(0, 1, 0, 3'b100, 32'h10, 32'h0);
    checks++; if (q !== 32'h000000BB) begin errors++; $display("FAIL lbu_byte10 got=%h exp=000000bb", q); end
    idle();
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy_m); end
  endtask

  task automatic test_byte_half();
    go(0, 0, 1, 3'b000, 32'h21, 32'h12345680);
    go(0, 1, 0, 3'b000, 32'h21, 32'h0);
    checks++; if (q !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext got=%h exp=ffffff80", q); end
    go(0, 1, 0, 3'b100, 32'h21, 32'h0);
    checks++; if (q !== 32'h00000080) begin errors++; $display("FAIL lbu_zext got=%h exp=00000080", q); end
    go(0, 1, 0, 3'b001, 32'h20, 32'h0);
    checks++; if (q !== 32'hFFFF8000) begin errors++; $display("FAIL lh_sext got=%h exp=ffff8000", q); end
    go(0, 1, 0, 3'b101, 32'h20, 32'h0);
    checks++; if (q !== 32'h00008000) begin errors++; $display("FAIL lhu_zext got=%h exp=00008000", q); end
    go(0, 1, 0, 3'b100, 32'h22, 32'h0);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL sb_neighbour got=%h exp=00000000", q); end
    idle();
  endtask

  task automatic test_misaligned();
    go(0, 0, 1, 3'b010, 32'h3FE, 32'h11223344);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL sw_misalign_err got=%b exp=1", e); end
    checks++; if (n !== 6) begin errors++; $display("FAIL sw_misalign_cycles got=%0d exp=6", n); end
    checks++; if (eb !== 1'b0) begin errors++; $display("FAIL sw_misalign_err_early got=%b exp=0", eb); end
    go(0, 1, 0, 3'b100, 32'h3FE, 32'h0);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL misalign_no_write_3fe got=%h exp=00000000", q); end
    go(0, 1, 0, 3'b100, 32'h0, 32'h0);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL misalign_no_write_000 got=%h exp=00000000", q); end
    go(0, 1, 0, 3'b001, 32'h21, 32'h0);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL lh_misalign_err got=%b exp=1", e); end
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL lh_misalign_data got=%h exp=00000000", q); end
    idle();
    go(1, 0, 1, 3'b010, 32'h3FE, 32'h11223344);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL noalign_sw_err got=%b exp=0", e); end
    go(1, 1, 0, 3'b100, 32'h3FE, 32'h0);
    checks++; if (q !== 32'h44) begin errors++; $display("FAIL noalign_b3fe got=%h exp=00000044", q); end
    go(1, 1, 0, 3'b100, 32'h3FF, 32'h0);
    checks++; if (q !== 32'h33) begin errors++; $display("FAIL noalign_b3ff got=%h exp=00000033", q); end
    go(1, 1, 0, 3'b100, 32'h400, 32'h0);
    checks++; if (q !== 32'h22) begin errors++; $display("FAIL noalign_b000 got=%h exp=00000022", q); end
    go(1, 1, 0, 3'b100, 32'h1, 32'h0);
    checks++; if (q !== 32'h11) begin errors++; $display("FAIL noalign_b001 got=%h exp=00000011", q); end
    go(1, 1, 0, 3'b010, 32'h3FE, 32'h0);
    checks++; if (q !== 32'h11223344) begin errors++; $display("FAIL noalign_lw_wrap got=%h exp=11223344", q); end
    idle();
  endtask

  task automatic test_illegal();
    go(0, 1, 0, 3'b010, 32'h10, 32'h0);
    checks++; if (q !== 32'h8899AABB) begin errors++; $display("FAIL pre_illegal_lw got=%h exp=8899aabb", q); end
    go(0, 1, 0, 3'b011, 32'h10, 32'h0);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL ld011_err got=%b exp=1", e); end
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL ld011_data got=%h exp=00000000", q); end
    checks++; if (n !== 6) begin errors++; $display("FAIL ld011_cycles got=%0d exp=6", n); end
    go(0, 0, 1, 3'b011, 32'h10, 32'h0);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL st011_err got=%b exp=1", e); end
    go(0, 1, 0, 3'b010, 32'h10, 32'h0);
    checks++; if (q !== 32'h8899AABB) begin errors++; $display("FAIL st011_no_write got=%h exp=8899aabb", q); end
    go(0, 1, 1, 3'b010, 32'h40, 32'hDEADBEEF);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL rw_err got=%b exp=0", e); end
    checks++; if (q !== 32'h8899AABB) begin errors++; $display("FAIL rw_rdata_held got=%h exp=8899aabb", q); end
    go(0, 1, 0, 3'b010, 32'h40, 32'h0);
    checks++; if (q !== 32'hDEADBEEF) begin errors++; $display("FAIL rw_store_done got=%h exp=deadbeef", q); end
    idle();
    checks++; if (err_m !== 1'b0) begin errors++; $display("FAIL err_after_done got=%b exp=0", err_m); end
  endtask

  task automatic test_back_to_back();
    go(2, 1, 0, 3'b010, 32'h8, 32'h0);
    checks++; if (n !== 2) begin errors++; $display("FAIL b2b_lw0_cycles got=%0d exp=2", n); end
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL b2b_lw0_data got=%h exp=00000000", q); end
    go(2, 0, 1, 3'b010, 32'h8, 32'hCAFEF00D);
    checks++; if (n !== 2) begin errors++; $display("FAIL b2b_sw_cycles got=%0d exp=2", n); end
    go(2, 1, 0, 3'b010, 32'h8, 32'h0);
    checks++; if (n !== 2) begin errors++; $display("FAIL b2b_lw1_cycles got=%0d exp=2", n); end
    checks++; if (q !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_lw1_data got=%h exp=cafef00d", q); end
    @(negedge CLK);
    drd = 0; dwr = 0;
    #1;
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL done_no_recapture got=%b exp=0", busy_m); end
    checks++; if (rd_m !== 32'hCAFEF00D) begin errors++; $display("FAIL rdata_hold got=%h exp=cafef00d", rd_m); end
    idle();
  endtask

  task automatic test_reset_mid();
    dsel = 0; drd = 0; dwr = 1; df3 = 3'b010; da = 32'h50; dwd = 32'hDEADBEEF;
    #1;
    @(negedge CLK);
    #1;
    @(negedge CLK);
    #1;
    RESET = 1'b1;
    dwr = 0;
    #1;
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", busy_m); end
    checks++; if (rd_m !== 32'h0) begin errors++; $display("FAIL midreset_rdata got=%h exp=00000000", rd_m); end
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    go(0, 1, 0, 3'b010, 32'h50, 32'h0);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL midreset_no_store got=%h exp=00000000", q); end
    go(0, 1, 0, 3'b010, 32'h10, 32'h0);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL reset_clears_mem got=%h exp=00000000", q); end
    idle();
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_misaligned();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
